// File: rtl/load_store_controller_pkg.sv
// Shared definitions for the load/store controller: memory op codes, FSM states,
// byte-enable patterns and the small decode helpers used by the controller.
package load_store_controller_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } lsc_state_e;

    // op[1:0] is the access size, op[2] selects zero-extension, op[3] marks a store
    typedef enum logic [OP_W-1:0] {
        OP_LB  = 4'd0,
        OP_LH  = 4'd1,
        OP_LW  = 4'd2,
        OP_LBU = 4'd4,
        OP_LHU = 4'd5,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10
    } mem_op_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [BE_W-1:0] BE_BYTE    = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

    // Per-transaction attributes held from accept until completion
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [1:0]      offset;
        logic            we;
    } lsc_op_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: legal = 1'b1;
            default:             legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic op_misaligned(input logic [OP_W-1:0] op, input logic [1:0] offset);
        logic mis;
        case (op[1:0])
            SIZE_HALF: mis = offset[0];
            SIZE_WORD: mis = (offset != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [BE_W-1:0] op_be(input logic [OP_W-1:0] op, input logic [1:0] offset);
        logic [BE_W-1:0] be;
        case (op[1:0])
            SIZE_BYTE: be = BE_BYTE << offset;
            SIZE_HALF: be = offset[1] ? BE_HALF_HI : BE_HALF_LO;
            default:   be = BE_WORD;
        endcase
        return be;
    endfunction

    function automatic logic [WORD_W-1:0] op_wdata(input logic [OP_W-1:0] op, input logic [WORD_W-1:0] wdata);
        logic [WORD_W-1:0] lanes;
        case (op[1:0])
            SIZE_BYTE: lanes = {4{wdata[7:0]}};
            SIZE_HALF: lanes = {2{wdata[15:0]}};
            default:   lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/load_store_controller_if.sv
// Data-memory bus between the load/store controller (master) and the memory (slave).
interface load_store_controller_if
    import load_store_controller_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              dmem_req_o;
    logic              dmem_we_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [DATA_W-1:0] dmem_wdata_o;
    logic [BE_W-1:0]   dmem_be_o;
    logic              dmem_gnt_i;
    logic              dmem_rvalid_i;
    logic [DATA_W-1:0] dmem_rdata_i;
    logic              dmem_err_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i, dmem_err_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i, dmem_err_i
    );
endinterface

// File: rtl/load_store_controller_load_aligner.sv
// Moves the addressed byte/half of a bus word down to bit 0 and sign- or
// zero-extends it according to the load op.
module load_aligner
    import load_store_controller_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [1:0]        offset_i,
    input  logic [WORD_W-1:0] rdata_i,
    output logic [WORD_W-1:0] data_c_o
);

    logic [WORD_W-1:0] shifted;

    always_comb begin
        shifted  = rdata_i >> {offset_i, 3'b000};
        data_c_o = shifted;
        case (op_i)
            OP_LB:   data_c_o = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  data_c_o = {24'd0, shifted[7:0]};
            OP_LH:   data_c_o = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  data_c_o = {16'd0, shifted[15:0]};
            default: data_c_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_controller.sv
// Load/store unit bridging the memory pipeline step to a req/gnt/rvalid data bus,
// with alignment checking, lane steering, load extension and a bus timeout.
module load_store_controller
    import load_store_controller_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_step_i,
    input  logic                mem_read_enable_i,
    input  logic                mem_write_enable_i,
    input  logic [OP_W-1:0]     memOp_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                misaligned_o,
    output logic                bus_error_o,
    load_store_controller_if.master dmem
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    lsc_op_t           op_q, op_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;

    logic              accept;
    logic              req_illegal;
    logic [WORD_W-1:0] load_data;

    assign accept      = enable_step_i && (mem_read_enable_i || mem_write_enable_i) && !rst_i;
    assign req_illegal = (mem_read_enable_i && mem_write_enable_i) || !op_is_legal(memOp_i);

    load_aligner u_load_aligner (
        .op_i     (op_q.op),
        .offset_i (op_q.offset),
        .rdata_i  (WORD_W'(dmem.dmem_rdata_i)),
        .data_c_o (load_data)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        done_d  = 1'b0;
        rdata_d = '0;
        mis_d   = 1'b0;
        berr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d.op     = memOp_i;
                    op_d.offset = addr_i[1:0];
                    op_d.we     = mem_write_enable_i;
                    we_d        = mem_write_enable_i;
                    addr_d      = {addr_i[ADDR_W-1:2], 2'b00};
                    be_d        = op_be(memOp_i, addr_i[1:0]);
                    wdata_d     = DATA_W'(op_wdata(memOp_i, WORD_W'(wdata_i)));
                    // Faulting requests complete immediately without touching the bus
                    if (req_illegal) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        berr_d  = 1'b1;
                    end else if (op_misaligned(memOp_i, addr_i[1:0])) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            ST_REQ: begin
                if (dmem.dmem_gnt_i) begin
                    state_d = ST_WAIT_RSP;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_RSP: begin
                if (dmem.dmem_rvalid_i) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    if (dmem.dmem_err_i) begin
                        berr_d = 1'b1;
                    end else if (!op_q.we) begin
                        rdata_d = DATA_W'(load_data);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    // busy must cover the accept cycle itself so the pipeline stalls immediately
    assign busy_o = (state_q == ST_REQ) || (state_q == ST_WAIT_RSP) ||
                    ((state_q == ST_IDLE) && accept);

    assign done_o            = done_q;
    assign rdata_o           = rdata_q;
    assign misaligned_o      = mis_q;
    assign bus_error_o       = berr_q;
    assign dmem.dmem_req_o   = req_q;
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_wdata_o = wdata_q;
    assign dmem.dmem_be_o    = be_q;

endmodule

// File: tb/tb_load_store_controller.sv
// Directed and randomized bench for load_store_controller against a transaction-level
// reference: expected timing, lanes and load values are derived from the access rules.
module tb_load_store_controller;

    localparam int unsigned TMO = 16;

    logic        clk;
    logic        rst_i;
    logic        enable_step_i;
    logic        mem_read_enable_i;
    logic        mem_write_enable_i;
    logic [3:0]  memOp_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misaligned_o;
    logic        bus_error_o;

    int errors = 0;
    int checks = 0;

    logic [3:0] legal_ops [8] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};

    load_store_controller_if #(.ADDR_W(32), .DATA_W(32)) dmem_if ();

    load_store_controller #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .enable_step_i      (enable_step_i),
        .mem_read_enable_i  (mem_read_enable_i),
        .mem_write_enable_i (mem_write_enable_i),
        .memOp_i            (memOp_i),
        .addr_i             (addr_i),
        .wdata_i            (wdata_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .rdata_o            (rdata_o),
        .misaligned_o       (misaligned_o),
        .bus_error_o        (bus_error_o),
        .dmem               (dmem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [3:0] op);
        return 1 << op[1:0];
    endfunction

    function automatic logic ref_legal(input logic [3:0] op);
        logic hit = 1'b0;
        for (int i = 0; i < 8; i++) if (legal_ops[i] == op) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [31:0] addr);
        int v = ((1 << ref_size(op)) - 1) << (addr % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] wd);
        logic [31:0] res;
        int s = ref_size(op);
        for (int i = 0; i < 4; i++) res[8*i +: 8] = wd[8*(i % s) +: 8];
        return res;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rd);
        int s = ref_size(op);
        logic [31:0] mask = (s == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * s)) - 1);
        logic [31:0] v = (rd >> (8 * (addr % 4))) & mask;
        if ((op == 4'd0 || op == 4'd1) && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "/busy"}, 32'(busy_o), 32'd0);
        chk({tag, "/done"}, 32'(done_o), 32'd0);
        chk({tag, "/rdata"}, rdata_o, 32'd0);
        chk({tag, "/mis"}, 32'(misaligned_o), 32'd0);
        chk({tag, "/berr"}, 32'(bus_error_o), 32'd0);
        chk({tag, "/req"}, 32'(dmem_if.dmem_req_o), 32'd0);
        chk({tag, "/we"}, 32'(dmem_if.dmem_we_o), 32'd0);
        chk({tag, "/addr"}, dmem_if.dmem_addr_o, 32'd0);
        chk({tag, "/wdata"}, dmem_if.dmem_wdata_o, 32'd0);
        chk({tag, "/be"}, 32'(dmem_if.dmem_be_o), 32'd0);
    endtask

    // One transaction: g = cycles before grant, r = cycles from grant to rvalid (>=1).
    // g >= TMO never grants; r > TMO never responds.
    task automatic do_txn(input string tag, input logic rd, input logic wr, input logic [3:0] op,
                          input logic [31:0] addr, input logic [31:0] wd, input int g, input int r,
                          input logic [31:0] rsp, input logic rerr);
        logic bad, mis, tmo, real_rsp;
        int done_cyc, req_end;
        logic [31:0] exp_rdata;
        bad      = (rd && wr) || !ref_legal(op);
        mis      = !bad && ((addr % ref_size(op)) != 0);
        tmo      = 1'b0;
        real_rsp = 1'b0;
        if (bad || mis) begin
            done_cyc = 1; req_end = 0;
        end else if (g >= int'(TMO)) begin
            done_cyc = 1 + TMO; req_end = TMO; tmo = 1'b1;
        end else begin
            req_end = 1 + g;
            if (r > int'(TMO)) begin
                done_cyc = g + 2 + TMO; tmo = 1'b1;
            end else begin
                done_cyc = g + r + 2; real_rsp = 1'b1;
            end
        end
        exp_rdata = (real_rsp && !wr && !rerr) ? ref_load(op, addr, rsp) : 32'd0;

        enable_step_i = 1'b1; mem_read_enable_i = rd; mem_write_enable_i = wr;
        memOp_i = op; addr_i = addr; wdata_i = wd;
        #1;
        chk($sformatf("%s/accept_busy", tag), 32'(busy_o), 32'd1);
        tick();

        for (int c = 1; c <= done_cyc + 1; c++) begin
            chk($sformatf("%s/c%0d/req", tag, c), 32'(dmem_if.dmem_req_o), 32'(c <= req_end));
            if (c <= req_end) begin
                chk($sformatf("%s/c%0d/addr", tag, c), dmem_if.dmem_addr_o, addr & 32'hFFFF_FFFC);
                chk($sformatf("%s/c%0d/be", tag, c), 32'(dmem_if.dmem_be_o), 32'(ref_be(op, addr)));
                chk($sformatf("%s/c%0d/we", tag, c), 32'(dmem_if.dmem_we_o), 32'(wr));
                if (wr) chk($sformatf("%s/c%0d/wdata", tag, c), dmem_if.dmem_wdata_o, ref_wdata(op, wd));
            end
            chk($sformatf("%s/c%0d/done", tag, c), 32'(done_o), 32'(c == done_cyc));
            chk($sformatf("%s/c%0d/busy", tag, c), 32'(busy_o), 32'(c < done_cyc));
            if (c == done_cyc) begin
                chk($sformatf("%s/mis", tag), 32'(misaligned_o), 32'(mis));
                chk($sformatf("%s/berr", tag), 32'(bus_error_o), 32'(bad || tmo || (real_rsp && rerr)));
                if (!(real_rsp && rerr)) chk($sformatf("%s/rdata", tag), rdata_o, exp_rdata);
            end else begin
                chk($sformatf("%s/c%0d/flags", tag, c), {rdata_o[29:0], misaligned_o, bus_error_o},
                    32'd0);
            end
            if (c <= done_cyc) begin
                // Unrelated pipeline requests while busy must be ignored
                enable_step_i = (c < done_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_read_enable_i = 1'b1; mem_write_enable_i = 1'($urandom_range(0, 1));
                memOp_i = 4'($urandom); addr_i = $urandom; wdata_i = $urandom;
                dmem_if.dmem_gnt_i    = (req_end > 0) && !(g >= int'(TMO)) && (c == 1 + g);
                dmem_if.dmem_rvalid_i = 1'b0;
                dmem_if.dmem_rdata_i  = $urandom;
                dmem_if.dmem_err_i    = 1'($urandom_range(0, 1));
                if (c <= req_end) begin
                    dmem_if.dmem_rvalid_i = 1'($urandom_range(0, 1));
                end else if (real_rsp && c == 1 + g + r) begin
                    dmem_if.dmem_rvalid_i = 1'b1;
                    dmem_if.dmem_rdata_i  = rsp;
                    dmem_if.dmem_err_i    = rerr;
                end
                tick();
            end
        end
        dmem_if.dmem_gnt_i = 1'b0; dmem_if.dmem_rvalid_i = 1'b0; dmem_if.dmem_err_i = 1'b0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] addr;
        logic        rd, wr;
        int          g, r;

        rst_i = 1'b1; enable_step_i = 1'b0; mem_read_enable_i = 1'b0; mem_write_enable_i = 1'b0;
        memOp_i = 4'd0; addr_i = 32'd0; wdata_i = 32'd0;
        dmem_if.dmem_gnt_i = 1'b0; dmem_if.dmem_rvalid_i = 1'b0;
        dmem_if.dmem_rdata_i = 32'd0; dmem_if.dmem_err_i = 1'b0;
        tick(); tick();
        check_idle_zero("reset");
        rst_i = 1'b0;
        tick();

        do_txn("lw_basic", 1, 0, 4'd2, 32'h100, 32'd0, 0, 1, 32'hDEADBEEF, 0);
        do_txn("lb_sign", 1, 0, 4'd0, 32'h103, 32'd0, 0, 1, 32'h8000_0000, 0);
        do_txn("lbu_zero", 1, 0, 4'd4, 32'h103, 32'd0, 0, 1, 32'h8000_0000, 0);
        do_txn("sh_hi", 0, 1, 4'd9, 32'h102, 32'h1234, 1, 2, 32'hFFFF_FFFF, 0);
        do_txn("lw_misal", 1, 0, 4'd2, 32'h101, 32'd0, 0, 1, 32'd0, 0);
        do_txn("lh_misal", 1, 0, 4'd1, 32'h203, 32'd0, 0, 1, 32'd0, 0);
        do_txn("both_en", 1, 1, 4'd2, 32'h100, 32'd0, 0, 1, 32'd0, 0);
        do_txn("illegal_op", 1, 0, 4'd3, 32'h100, 32'd0, 0, 1, 32'd0, 0);
        do_txn("gnt_timeout", 1, 0, 4'd2, 32'h300, 32'd0, TMO, 1, 32'd0, 0);
        do_txn("rsp_timeout", 0, 1, 4'd10, 32'h304, 32'hCAFEF00D, 2, TMO + 1, 32'd0, 0);
        do_txn("rsp_err", 1, 0, 4'd5, 32'h306, 32'd0, 1, 1, 32'h1234_5678, 1);
        do_txn("lh_hi", 1, 0, 4'd1, 32'h402, 32'd0, 0, 3, 32'h8001_7FFF, 0);

        // Reset while waiting for the response; the late rvalid must be ignored
        enable_step_i = 1'b1; mem_read_enable_i = 1'b1; mem_write_enable_i = 1'b0;
        memOp_i = 4'd2; addr_i = 32'h500; wdata_i = 32'd0;
        tick();
        enable_step_i = 1'b0;
        chk("rst_wait/req", 32'(dmem_if.dmem_req_o), 32'd1);
        dmem_if.dmem_gnt_i = 1'b1;
        tick();
        dmem_if.dmem_gnt_i = 1'b0;
        chk("rst_wait/in_wait_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_idle_zero("rst_wait/after_rst");
        dmem_if.dmem_rvalid_i = 1'b1; dmem_if.dmem_rdata_i = 32'hA5A5_A5A5;
        tick();
        dmem_if.dmem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle_zero($sformatf("rst_wait/late_rvalid%0d", i));
            tick();
        end
        do_txn("post_rst_lw", 1, 0, 4'd2, 32'h600, 32'd0, 0, 1, 32'h0BAD_F00D, 0);

        for (int i = 0; i < 40; i++) begin
            op = legal_ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr = addr & ~32'(ref_size(op) - 1);
            wr = op[3]; rd = !op[3];
            if ($urandom_range(0, 14) == 0) begin rd = 1'b1; wr = 1'b1; end
            g = $urandom_range(0, 3);
            r = $urandom_range(1, 3);
            if ($urandom_range(0, 11) == 0) g = TMO;
            else if ($urandom_range(0, 11) == 0) r = TMO + 1;
            do_txn($sformatf("rnd%0d", i), rd, wr, op, addr, $urandom, g, r, $urandom,
                   ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_controller.md
LOAD_STORE_CONTROLLER -- requirements
Module: load_store_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16, maximum cycles spent waiting for grant or response.
REQ-004 SHALL have ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- enable_step_i  in  1  access request from memory step
- mem_read_enable_i  in  1  load
- mem_write_enable_i  in  1  store
- memOp_i  in  4  access size/sign code
- addr_i  in  ADDR_W  byte address
- wdata_i  in  DATA_W  store data
- busy_o  out  1  pipeline stall
- done_o  out  1  completion pulse
- rdata_o  out  DATA_W  aligned, extended load data
- misaligned_o  out  1  alignment fault
- bus_error_o  out  1  bus/timeout/illegal fault
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  bus write
- dmem_addr_o  out  ADDR_W  word-aligned address
- dmem_wdata_o  out  DATA_W  lane-replicated store data
- dmem_be_o  out  4  byte enables
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  response valid
- dmem_rdata_i  in  DATA_W  read data
- dmem_err_i  in  1  response error, qualified by rvalid

Function
REQ-005 SHALL use a four-state FSM: IDLE, REQ, WAIT_RSP, DONE.
REQ-006 In IDLE, enable_step_i with exactly one of read/write enable SHALL latch op/addr/wdata and go to REQ.
REQ-007 SHALL latch the request the same cycle without a bus access when:
- read and write enables are both high;
- memOp_i is not one of LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=8, SH=9, SW=10;
- the access is misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-008 On such a request SHALL go to DONE with misaligned_o set for misalignment, else bus_error_o set.
REQ-009 In REQ SHALL hold dmem_req_o=1 with stable address/we/be/wdata until dmem_gnt_i, then go to WAIT_RSP.
REQ-010 In WAIT_RSP, dmem_rvalid_i SHALL capture the response and go to DONE; dmem_err_i set bus_error_o.
REQ-011 A response arriving in the grant cycle SHALL NOT be accepted; the earliest response is one cycle after grant.
REQ-012 A counter SHALL reset on entry to REQ and to WAIT_RSP and increment each cycle in either state; on reaching TIMEOUT_CYC SHALL drop the request, set bus_error_o and go to DONE.
REQ-013 DONE SHALL last exactly one cycle with done_o=1; fault flags and rdata_o SHALL be valid only while done_o=1, otherwise 0; then go to IDLE.
REQ-014 busy_o SHALL be 1 in IDLE when a request is accepted and in REQ and WAIT_RSP; it SHALL be 0 in DONE and otherwise in IDLE.
REQ-015 Minimum latency SHALL be accept -> done_o in 3 cycles (grant in the REQ cycle, rvalid on the next cycle).
REQ-016 Byte enables SHALL be: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111.
REQ-017 Store data SHALL be replicated across lanes: byte x4, half x2.
REQ-018 Loads SHALL shift dmem_rdata_i by addr[1:0] bytes, then sign-extend (LB/LH) or zero-extend (LBU/LHU); stores SHALL return rdata_o=0.
REQ-019 Requests while not in IDLE SHALL be ignored; the pipeline holds them under busy_o.

Reset
REQ-020 With rst_i high at a clock edge the block SHALL go to IDLE with every output 0, abandoning any outstanding transaction, including in WAIT_RSP.
REQ-021 After reset SHALL ignore dmem_rvalid_i until its own next grant.

Structure
REQ-022 memOp codes, FSM state codes and the BE patterns SHALL live in the shared definitions header.
REQ-023 Load alignment/extension SHALL be a combinational sub-module load_aligner (op, offset, rdata -> extended data).

Verification
REQ-024 LW at 0x100, gnt at once, rvalid next cycle with data 0xDEADBEEF -> done_o 3 cycles after accept, rdata_o=0xDEADBEEF, dmem_be_o=1111.
REQ-025 LB at 0x103, rdata 0x80000000 -> rdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-026 SH at 0x102, wdata 0x1234 -> dmem_be_o=1100, dmem_wdata_o=0x12341234, rdata_o=0.
REQ-027 LW at 0x101 -> no dmem_req_o, done_o one cycle after accept with misaligned_o=1.
REQ-028 Grant never asserted -> bus_error_o and done_o after TIMEOUT_CYC cycles, dmem_req_o dropped.
REQ-029 rst_i asserted in WAIT_RSP, then a late rvalid -> stays in IDLE, all outputs 0, no done_o.
